sram_req_master: RTL and testbench

Request-side controller that owns both ports of one generic 16-bit SRAM instance in the LSTM datapath. It accepts single read/write requests from a compute engine over a valid/ready handshake and drives the SRAM write and read ports from registers. It absorbs the SRAM's one-cycle registered read latency and avoids its read-after-write X window by stalling. Read data returns in order through a small response FIFO with backpressure.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_req_master_if.sv | 30 +++
 rtl/sram_rsp_fifo.sv | 62 ++++++
 rtl/sram_req_master.sv | 111 +++++++++++
 tb/tb_sram_req_master.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared widths, request record and word-address helper for the SRAM
// request master and its response FIFO.
package sram_pkg;

    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 16;
    localparam int RSP_DEPTH_DEF = 4;

    // One request from the compute engine.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // The SRAM is 16 bits wide, so a word covers two byte addresses.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
        return addr >> 1;
    endfunction

endpackage

// File: rtl/sram_req_master_if.sv
// Request/response handshake between the compute engine (master) and the
// SRAM request controller (slave).
interface sram_req_master_if
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read data until the consumer takes it.
// Overflow protection lives upstream in the credit check, so a push is
// always accepted; a pop on an empty FIFO is ignored.
module sram_rsp_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A push into a full FIFO means the credit accounting is broken.
    no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !do_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/sram_req_master.sv
// Request-side controller for one dual-port 16-bit SRAM. Accepts single
// read/write requests, registers them onto the SRAM ports, hides the
// SRAM's one-cycle read latency and returns read data in order through a
// credit-protected response FIFO.
module sram_req_master
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    sram_req_master_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] read_data
);

    localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam int USED_W = CNT_W + 1;

    req_t              req;
    logic              accept;
    logic              hazard;
    logic              credit_ok;
    logic              ready;
    logic [USED_W-1:0] used;

    // Pipeline valid bits: read in the issue stage, read being sampled by the SRAM.
    logic              iss_rd_v;
    logic              sram_rd_v;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_pop;

    assign req = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

    // Hazard and credit decisions for the request currently presented.
    always_comb begin
        hazard    = 1'b0;
        used      = USED_W'(iss_rd_v) + USED_W'(sram_rd_v) + USED_W'(fifo_count);
        credit_ok = (used < USED_W'(RSP_DEPTH));
        // A write sitting in the issue stage has not reached the array yet.
        if (!req.write && write_enable &&
            (word_addr(req.addr) == word_addr(write_address))) begin
            hazard = 1'b1;
        end
        ready = !hazard && (req.write || credit_ok);
    end

    assign bus.req_ready = ready;
    assign accept        = bus.req_valid && ready;

    // Issue stage: register accepted requests onto the SRAM ports.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            read_address  <= '0;
            iss_rd_v      <= 1'b0;
        end else begin
            write_enable <= accept && req.write;
            iss_rd_v     <= accept && !req.write;
            if (accept && req.write) begin
                write_address <= req.addr;
                write_data    <= req.wdata;
            end
            // Read address holds between reads so the SRAM never sees X.
            if (accept && !req.write) begin
                read_address <= req.addr;
            end
        end
    end

    // SRAM stage: the read sampled at this edge returns data next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            sram_rd_v <= 1'b0;
        end else begin
            sram_rd_v <= iss_rd_v;
        end
    end

    assign fifo_pop      = bus.rsp_valid && bus.rsp_ready;
    assign bus.rsp_valid = !fifo_empty;

    sram_rsp_fifo #(
        .DEPTH      (RSP_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (sram_rd_v),
        .push_data (read_data),
        .pop       (fifo_pop),
        .pop_data  (bus.rsp_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // No read may be accepted against a pending write to the same word.
    no_raw_accept: assert property (@(posedge clock) disable iff (reset)
        (accept && !req.write && write_enable) |->
        (word_addr(req.addr) != word_addr(write_address)));

endmodule

// File: tb/tb_sram_req_master.sv
`timescale 1ns/1ps
module tb_sram_req_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_req_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) bus();

    logic [31:0] write_address;
    logic [15:0] write_data;
    logic        write_enable;
    logic [31:0] read_address;
    logic [15:0] read_data;

    sram_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .RSP_DEPTH(4)) dut (
        .clock         (clk),
        .reset         (rst),
        .bus           (bus),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .read_address  (read_address),
        .read_data     (read_data)
    );

    // SRAM model: registered read, and X when reading a word being written
    // at this edge or written at the previous edge.
    logic [15:0] sram [256];
    logic        prev_we;
    logic [7:0]  prev_word;
    always @(posedge clk) begin
        if ((write_enable && read_address[8:1] == write_address[8:1]) ||
            (prev_we && read_address[8:1] == prev_word))
            read_data <= 'x;
        else
            read_data <= sram[read_address[8:1]];
        if (write_enable) sram[write_address[8:1]] <= write_data;
        prev_we   <= write_enable;
        prev_word <= write_address[8:1];
    end

    // Reference model: memory contents as seen in acceptance order, plus
    // the queue of read results the DUT owes.
    logic [15:0] ref_mem [256];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          got_edge[$];
    int          edge_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
    end

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_edge.delete();
    endtask

    // One clock: drive at negedge, observe handshakes, then take the edge.
    task automatic step(input logic rs, input logic v, input logic w,
                        input logic [31:0] a, input logic [15:0] d,
                        input logic rr, output logic acc);
        @(negedge clk);
        rst = rs;
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
        #1;
        acc = !rs && v && bus.req_ready;
        if (rs) begin
            clear_q();
        end else begin
            if (bus.rsp_valid && rr) begin
                got_q.push_back(bus.rsp_rdata);
                got_edge.push_back(edge_cnt + 1);
            end
            if (acc) begin
                if (w) ref_mem[a[8:1]] = d;
                else   exp_q.push_back(ref_mem[a[8:1]]);
            end
        end
        @(posedge clk);
        edge_cnt++;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [15:0] d,
                         input logic rr, output int stalls, output int acc_edge);
        logic acc;
        stalls = 0;
        acc = 1'b0;
        while (!acc && stalls < 20) begin
            step(1'b0, 1'b1, w, a, d, rr, acc);
            if (!acc) stalls++;
        end
        acc_edge = edge_cnt;
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        repeat (n) step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, rr, acc);
    endtask

    task automatic drain(input int target);
        logic acc;
        int b = 0;
        while (got_q.size() < target && b < 60) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, acc);
            b++;
        end
    endtask

    task automatic test_reset();
        logic acc;
        step(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, acc);
        step(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, acc);
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL reset_write_enable got=%b exp=0", write_enable); end
        n_cmp++; if (write_address !== 32'h0) begin n_err++; $display("FAIL reset_write_address got=%h exp=0", write_address); end
        n_cmp++; if (write_data !== 16'h0) begin n_err++; $display("FAIL reset_write_data got=%h exp=0", write_data); end
        n_cmp++; if (read_address !== 32'h0) begin n_err++; $display("FAIL reset_read_address got=%h exp=0", read_address); end
    endtask

    task automatic test_raw_stall();
        int st, w_edge, r_edge;
        clear_q();
        issue(1'b1, 32'h10, 16'h1234, 1'b1, st, w_edge);
        n_cmp++; if (st !== 0) begin n_err++; $display("FAIL raw_write_stall got=%0d exp=0", st); end
        issue(1'b0, 32'h10, 16'h0, 1'b1, st, r_edge);
        n_cmp++; if (st !== 1) begin n_err++; $display("FAIL raw_read_stall got=%0d exp=1", st); end
        n_cmp++; if (r_edge !== w_edge + 2) begin n_err++; $display("FAIL raw_accept_edge got=%0d exp=%0d", r_edge, w_edge + 2); end
        drain(1);
        n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL raw_rsp_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== 16'h1234) begin n_err++; $display("FAIL raw_rsp_data got=%h exp=1234", got_q[0]); end
            n_cmp++; if (got_edge[0] !== r_edge + 3) begin n_err++; $display("FAIL raw_rsp_edge got=%0d exp=%0d", got_edge[0], r_edge + 3); end
        end
    endtask

    task automatic test_same_word();
        int st, e;
        clear_q();
        issue(1'b1, 32'h20, 16'hBEEF, 1'b1, st, e);
        issue(1'b0, 32'h21, 16'h0, 1'b1, st, e);
        n_cmp++; if (st !== 1) begin n_err++; $display("FAIL odd_byte_stall got=%0d exp=1", st); end
        drain(1);
        n_cmp++; if (got_q.size() < 1 || got_q[0] !== 16'hBEEF) begin
            n_err++; $display("FAIL odd_byte_data got=%h exp=beef", (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        clear_q();
        issue(1'b1, 32'h22, 16'hCAFE, 1'b1, st, e);
        idle(2, 1'b1);
        issue(1'b1, 32'h20, 16'h1111, 1'b1, st, e);
        issue(1'b0, 32'h22, 16'h0, 1'b1, st, e);
        n_cmp++; if (st !== 0) begin n_err++; $display("FAIL next_word_stall got=%0d exp=0", st); end
        drain(1);
        n_cmp++; if (got_q.size() < 1 || got_q[0] !== 16'hCAFE) begin
            n_err++; $display("FAIL next_word_data got=%h exp=cafe", (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] data [8];
        int st, e, first;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            data[i] = 16'($urandom);
            issue(1'b1, 32'(2 * i), data[i], 1'b1, st, e);
        end
        idle(2, 1'b1);
        clear_q();
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 32'(2 * i), 16'h0, 1'b1, st, e);
            if (i == 0) first = e;
            n_cmp++; if (st !== 0) begin n_err++; $display("FAIL b2b_ready read=%0d stalls=%0d exp=0", i, st); end
        end
        drain(8);
        n_cmp++; if (got_q.size() !== 8) begin n_err++; $display("FAIL b2b_rsp_count got=%0d exp=8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== data[i]) begin n_err++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, got_q[i], data[i]); end
            n_cmp++; if (got_edge[i] !== first + 3 + i) begin n_err++; $display("FAIL b2b_edge idx=%0d got=%0d exp=%0d", i, got_edge[i], first + 3 + i); end
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        int k, n_acc, b;
        clear_q();
        k = 0;
        n_acc = 0;
        acc = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1, 1'b0, 32'(2 * k), 16'h0, 1'b0, acc);
            if (acc) begin k++; n_acc++; end
        end
        n_cmp++; if (n_acc !== 4) begin n_err++; $display("FAIL credit_accepts got=%0d exp=4", n_acc); end
        n_cmp++; if (acc !== 1'b0) begin n_err++; $display("FAIL credit_ready_low got=%b exp=0", acc); end
        step(1'b0, 1'b1, 1'b1, 32'h80, 16'h7E57, 1'b0, acc);
        n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL credit_write_ok got=%b exp=1", acc); end
        b = 0;
        while (k < 6 && b < 30) begin
            step(1'b0, 1'b1, 1'b0, 32'(2 * k), 16'h0, 1'b1, acc);
            if (acc) k++;
            b++;
        end
        n_cmp++; if (k !== 6) begin n_err++; $display("FAIL credit_resume got=%0d exp=6", k); end
        drain(6);
        n_cmp++; if (got_q.size() !== 6) begin n_err++; $display("FAIL credit_rsp_count got=%0d exp=6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL credit_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        logic acc;
        int st, e;
        clear_q();
        issue(1'b0, 32'h0, 16'h0, 1'b0, st, e);
        issue(1'b0, 32'h2, 16'h0, 1'b0, st, e);
        idle(3, 1'b0);
        issue(1'b0, 32'h4, 16'h0, 1'b0, st, e);
        issue(1'b0, 32'h6, 16'h0, 1'b0, st, e);
        step(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, acc);
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL midrst_write_enable got=%b exp=0", write_enable); end
        n_cmp++; if (read_address !== 32'h0) begin n_err++; $display("FAIL midrst_read_address got=%h exp=0", read_address); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_req_ready got=%b exp=1", bus.req_ready); end
        idle(6, 1'b1);
        n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL midrst_stale_rsp got=%0d exp=0", got_q.size()); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rsp_after got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_idle();
        logic acc;
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 1'b1, acc);
            #1;
            n_cmp++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL idle_write_enable cycle=%0d got=%b exp=0", c, write_enable); end
            n_cmp++; if ($isunknown(read_address)) begin n_err++; $display("FAIL idle_read_address cycle=%0d got=%h exp=known", c, read_address); end
        end
    endtask

    task automatic test_random();
        logic        acc, pend, pw, rr;
        logic [31:0] pa;
        logic [15:0] pd;
        int          target;
        clear_q();
        pend = 1'b0;
        pw = 1'b0;
        pa = '0;
        pd = '0;
        for (int c = 0; c < 200; c++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend = 1'b1;
                pw   = 1'($urandom_range(0, 1));
                pa   = 32'($urandom_range(0, 15));
                pd   = 16'($urandom);
            end
            rr = ($urandom_range(0, 3) != 0);
            step(1'b0, pend, pw, pa, pd, rr, acc);
            if (acc) pend = 1'b0;
        end
        target = exp_q.size();
        drain(target);
        n_cmp++; if (got_q.size() !== target) begin n_err++; $display("FAIL rand_rsp_count got=%0d exp=%0d", got_q.size(), target); end
        for (int i = 0; i < got_q.size() && i < target; i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raw_stall();
        test_same_word();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
